// File: rtl/tone_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tone_pkg
//  Description : Shared definitions for the tone scheduler. This package holds
//                the FSM state encoding, the note terminal-count table
//                (C4..C5 at a 12 MHz clock) and the note-selection helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package tone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // The half-period of note i is NOTE_TC(i)+1 clock cycles.
    function automatic logic [15:0] note_tc(input logic [2:0] idx);
        logic [15:0] tc;
        case (idx)
            3'd0:    tc = 16'd22932;
            3'd1:    tc = 16'd20430;
            3'd2:    tc = 16'd18201;
            3'd3:    tc = 16'd17180;
            3'd4:    tc = 16'd15305;
            3'd5:    tc = 16'd13635;
            3'd6:    tc = 16'd12148;
            default: tc = 16'd11466;
        endcase
        return tc;
    endfunction

    // This returns the lowest pressed index, or 0 when nothing is pressed.
    function automatic logic [2:0] lowest_pressed(input logic [7:0] pressed);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pressed[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // This returns the next pressed index strictly above cur, wrapping 7 -> 0.
    // The scan runs from the farthest offset to the nearest so that the
    // nearest pressed index wins. Offset 8 wraps onto cur itself, which
    // makes a lone held button select itself.
    function automatic logic [2:0] next_above(input logic [7:0] pressed,
                                              input logic [2:0] cur);
        logic [2:0] idx;
        logic [2:0] j;
        idx = cur;
        for (int k = 8; k >= 1; k--) begin
            j = cur + 3'(k);
            if (pressed[j]) idx = j;
        end
        return idx;
    endfunction

endpackage : tone_pkg
`default_nettype wire

// File: rtl/tone_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tone_debounce
//  Description : One button channel. The channel has a 2-flop synchronizer
//                followed by a debouncer. The debounced level flips only
//                after DEBOUNCE_CYCLES consecutive cycles in which the
//                synchronized input differs from it.
//  Ports       : clk       - clock
//                rst_n     - asynchronous active-low reset
//                i_btn     - raw active-low button, asynchronous to clk
//                o_pressed - 1 while the debounced level is low
//  Revision    : 1.0 - initial release
// ============================================================================
module tone_debounce #(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pressed
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] c_cnt_last = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic [CW-1:0] r_cnt;

    // The synchronizer and the debounced level reset to 1 (released), so a
    // button held through reset must be fully re-debounced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_db    <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_db) begin
                if (r_cnt == c_cnt_last) begin
                    r_db  <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_pressed = ~r_db;

endmodule : tone_debounce
`default_nettype wire

// File: rtl/tone_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tone_scheduler
//  Description : Eight-button square-wave tone player. Buttons are
//                synchronized and debounced. An IDLE/PLAY/GAP FSM latches a
//                note and drives a 16-bit divider that toggles the square
//                output. When the selected note changes, a short silence
//                (GAP) separates the two notes.
//                Optional macro TONE_ARP_EN: in PLAY, a step timer advances
//                to the next pressed note above the current one, which gives
//                an arpeggio.
//  Ports       : clk    - clock
//                rst_n  - asynchronous active-low reset
//                btn    - raw active-low buttons [7:0]
//                pwmout - square-wave audio
//                ledc   - [2:0] latched note, [3] playing, [5:4] state code
//  Revision    : 1.0 - initial release
// ============================================================================
module tone_scheduler
    import tone_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int GAP_CYCLES      = 12000,
    parameter int STEP_CYCLES     = 1200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] btn,
    output logic       pwmout,
    output logic [5:0] ledc
);

    localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] c_gap_last = GW'(GAP_CYCLES - 1);

    logic [7:0]  w_pressed;
    logic        w_any;
    logic [2:0]  w_cand;
    logic [15:0] w_tc;
    logic        w_div_hit;
    logic [15:0] w_div_next;
    logic        w_sq_next;

    state_t      r_state;
    logic [2:0]  r_note;
    logic [15:0] r_div;
    logic        r_square;
    logic [GW-1:0] r_gap;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_btn
            tone_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_db (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_btn     (btn[gi]),
                .o_pressed (w_pressed[gi])
            );
        end
    endgenerate

    assign w_any = |w_pressed;

`ifdef TONE_ARP_EN
    localparam int SW = (STEP_CYCLES < 2) ? 1 : $clog2(STEP_CYCLES + 1);
    localparam logic [SW-1:0] c_step_last = SW'(STEP_CYCLES - 1);

    logic [SW-1:0] r_step;
    logic          w_step_end;

    assign w_cand     = next_above(w_pressed, r_note);
    assign w_step_end = (r_step == c_step_last);
`else
    assign w_cand = lowest_pressed(w_pressed);
`endif

    assign w_tc       = note_tc(r_note);
    assign w_div_hit  = (r_div == w_tc);
    assign w_div_next = w_div_hit ? 16'd0 : r_div + 16'd1;
    assign w_sq_next  = r_square ^ w_div_hit;

    // The square is cleared on the same edge that leaves PLAY. This means
    // r_square already equals (square AND playing), and it can drive pwmout
    // directly without a glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_note   <= 3'd0;
            r_div    <= 16'd0;
            r_square <= 1'b0;
            r_gap    <= '0;
`ifdef TONE_ARP_EN
            r_step   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_div    <= 16'd0;
                    r_square <= 1'b0;
                    r_gap    <= '0;
                    if (w_any) begin
                        r_state <= ST_PLAY;
                        r_note  <= w_cand;
`ifdef TONE_ARP_EN
                        r_step  <= '0;
`endif
                    end
                end

                ST_PLAY: begin
                    if (!w_any) begin
                        r_state  <= ST_IDLE;
                        r_div    <= 16'd0;
                        r_square <= 1'b0;
`ifdef TONE_ARP_EN
                    end else if (w_step_end && (w_cand != r_note)) begin
`else
                    end else if (w_cand != r_note) begin
`endif
                        r_state  <= ST_GAP;
                        r_div    <= 16'd0;
                        r_square <= 1'b0;
                        r_gap    <= '0;
                    end else begin
                        r_div    <= w_div_next;
                        r_square <= w_sq_next;
`ifdef TONE_ARP_EN
                        r_step   <= w_step_end ? '0 : r_step + 1'b1;
`endif
                    end
                end

                ST_GAP: begin
                    r_div    <= 16'd0;
                    r_square <= 1'b0;
                    if (r_gap == c_gap_last) begin
                        r_gap <= '0;
                        if (w_any) begin
                            r_state <= ST_PLAY;
                            r_note  <= w_cand;
`ifdef TONE_ARP_EN
                            r_step  <= '0;
`endif
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_div    <= 16'd0;
                    r_square <= 1'b0;
                    r_gap    <= '0;
                end
            endcase
        end
    end

    assign pwmout = r_square;
    assign ledc   = {r_state, (r_state == ST_PLAY), r_note};

endmodule : tone_scheduler
`default_nettype wire

// File: doc/tone_scheduler.md
TONE_SCHEDULER -- requirements
Module: tone_scheduler

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 120000, cycles a button must be stable before its debounced state changes.
REQ-002 SHALL have parameter GAP_CYCLES, default 12000, silence length between two different notes.
REQ-003 SHALL have parameter STEP_CYCLES, default 1200000, arpeggio step length (used only with TONE_ARP_EN).
REQ-004 SHALL have port clk  input  1  sole clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port btn  input  8  raw buttons, active-low, asynchronous to clk.
REQ-007 SHALL have port pwmout  output  1  square-wave audio.
REQ-008 SHALL have port ledc  output  6  status: [2:0] latched note index, [3] playing, [5:4] state code.

Function
REQ-009 SHALL pass each btn bit through a 2-flop synchronizer, then a per-button debouncer whose state changes only after DEBOUNCE_CYCLES consecutive cycles of differing synchronized input; pressed = debounced low.
REQ-010 SHALL implement states IDLE (code 0), PLAY (code 1), GAP (code 2); code 3 unused and SHALL return to IDLE.
REQ-011 SHALL select a candidate note: without TONE_ARP_EN, lowest pressed index.
REQ-012 IDLE -> PLAY when any button is pressed: latch candidate, clear divider counter, square output 0.
REQ-013 PLAY -> IDLE when no button is pressed, same cycle detected.
REQ-014 PLAY -> GAP when candidate differs from latched note; GAP lasts exactly GAP_CYCLES cycles.
REQ-015 At GAP end: if any pressed, latch candidate evaluated that cycle, clear divider, -> PLAY; else -> IDLE.
REQ-016 Divider: 16-bit counter increments each PLAY cycle; on reaching the latched note's terminal count N it SHALL clear and toggle the square, giving period 2*(N+1) cycles.
REQ-017 Divider counter and square SHALL hold at 0 in IDLE and GAP.
REQ-018 pwmout SHALL equal square AND (state == PLAY), registered, with no glitch on state exit.
REQ-019 Latched note SHALL change only at IDLE->PLAY or GAP->PLAY, never mid-PLAY.
REQ-020 ledc[3] SHALL be 1 only in PLAY; ledc[2:0] SHALL show the latched index (0 after reset).

Reset
REQ-021 rst_n low SHALL immediately force state IDLE, all counters 0, debounced states released, synchronizer flops 1, latched note 0, pwmout 0, ledc 0.
REQ-022 Reset deassertion mid-press SHALL require full DEBOUNCE_CYCLES before any note starts.

Configuration
REQ-023 With TONE_ARP_EN defined: in PLAY a step timer SHALL count to STEP_CYCLES-1, then candidate = next pressed index strictly above latched, wrapping from 7 to 0; if it differs -> GAP; timer clears on entering PLAY.
REQ-024 With TONE_ARP_EN defined and a single button held, candidate equals latched and PLAY SHALL continue without a gap.
REQ-025 Without TONE_ARP_EN: no step timer logic; REQ-011 selection only.

Structure
REQ-026 Package tone_pkg SHALL hold the state encoding and NOTE_TC table: 22932, 20430, 18201, 17180, 15305, 13635, 12148, 11466 (C4..C5 at 12 MHz).
REQ-027 Sub-module tone_debounce SHALL implement one synchronizer+debouncer channel, instantiated 8 times.

Verification
REQ-028 Bench SHALL use DEBOUNCE_CYCLES=4, GAP_CYCLES=2, STEP_CYCLES=50.
REQ-029 Press btn[4] (btn=8'hEF) -> after 2 sync + 4 stable cycles state PLAY, ledc=6'b011100, pwmout toggles every 15306 cycles.
REQ-030 btn[4] held, then also btn[1] -> pwmout 0 for exactly 2 cycles (GAP), then PLAY with ledc[2:0]=1, half-period 20431.
REQ-031 1-cycle low pulse on btn[0] -> no debounced press, state stays IDLE, pwmout 0.
REQ-032 rst_n asserted mid-PLAY -> pwmout and ledc 0 same cycle without clk edge; after release, no note until re-debounced.
REQ-033 TONE_ARP_EN, btn[2] and btn[6] held -> latched alternates 2,6,2 with each switch after 50 PLAY cycles plus 2-cycle gap.
REQ-034 Release all buttons during GAP -> state IDLE at GAP end, ledc[3]=0.
